// File: rtl/mandelbrot_iter_ctrl_if.sv
// Pixel-in, iteration-logic and result-out signals of the Mandelbrot iteration controller.
// The master modport is the controller; the slave modport is its surrounding datapath.
interface mandelbrot_iter_ctrl_if #(
    parameter int Q_LEN  = 46,
    parameter int ITER_W = 8,
    parameter int TAG_W  = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [Q_LEN-1:0]  in_c_real;
    logic [Q_LEN-1:0]  in_c_imag;
    logic [TAG_W-1:0]  in_tag;

    logic [Q_LEN-1:0]  lg_z_real;
    logic [Q_LEN-1:0]  lg_z_imag;
    logic [Q_LEN-1:0]  lg_c_real;
    logic [Q_LEN-1:0]  lg_c_imag;
    logic [Q_LEN-1:0]  lg_next_z_real;
    logic [Q_LEN-1:0]  lg_next_z_imag;
    logic              lg_finished;

    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;
    logic [TAG_W-1:0]  out_tag;

    logic              busy;

    modport master (
        input  in_valid, in_c_real, in_c_imag, in_tag,
        input  lg_next_z_real, lg_next_z_imag, lg_finished,
        input  out_ready,
        output in_ready,
        output lg_z_real, lg_z_imag, lg_c_real, lg_c_imag,
        output out_valid, out_iter, out_escaped, out_tag,
        output busy
    );

    modport slave (
        output in_valid, in_c_real, in_c_imag, in_tag,
        output lg_next_z_real, lg_next_z_imag, lg_finished,
        output out_ready,
        input  in_ready,
        input  lg_z_real, lg_z_imag, lg_c_real, lg_c_imag,
        input  out_valid, out_iter, out_escaped, out_tag,
        input  busy
    );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Drives external z^2+c logic one pixel at a time; result valid k+1 edges after accept (escape at k).
// One pixel in flight: in_ready only in IDLE, result held in DONE until out_ready.
module mandelbrot_iter_ctrl #(
    parameter int Q_LEN    = 46,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int TAG_W    = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    mandelbrot_iter_ctrl_if.master bus
);
    localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [Q_LEN-1:0]  z_re;
    logic [Q_LEN-1:0]  z_im;
    logic [Q_LEN-1:0]  c_re;
    logic [Q_LEN-1:0]  c_im;
    logic [TAG_W-1:0]  tag_q;
    logic [ITER_W-1:0] n;

    logic [ITER_W-1:0] res_iter;
    logic              res_escaped;
    logic [TAG_W-1:0]  res_tag;

    logic              at_cap;

    assign at_cap = (n == MAX_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)                 state_nxt = ITER;
            ITER: if (bus.lg_finished || at_cap)    state_nxt = DONE;
            DONE: if (bus.out_ready)                state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // Escape is checked before the cap, and the cap before the increment, so n never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_re        <= '0;
            z_im        <= '0;
            c_re        <= '0;
            c_im        <= '0;
            tag_q       <= '0;
            n           <= '0;
            res_iter    <= '0;
            res_escaped <= 1'b0;
            res_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        c_re  <= bus.in_c_real;
                        c_im  <= bus.in_c_imag;
                        tag_q <= bus.in_tag;
                        z_re  <= '0;
                        z_im  <= '0;
                        n     <= '0;
                    end
                end
                ITER: begin
                    if (bus.lg_finished) begin
                        res_iter    <= n;
                        res_escaped <= 1'b1;
                        res_tag     <= tag_q;
                    end else if (at_cap) begin
                        res_iter    <= MAX_N;
                        res_escaped <= 1'b0;
                        res_tag     <= tag_q;
                    end else begin
                        z_re <= bus.lg_next_z_real;
                        z_im <= bus.lg_next_z_imag;
                        n    <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.busy        = (state == ITER);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_iter    = res_iter;
    assign bus.out_escaped = res_escaped;
    assign bus.out_tag     = res_tag;

    assign bus.lg_z_real   = z_re;
    assign bus.lg_z_imag   = z_im;
    assign bus.lg_c_real   = c_re;
    assign bus.lg_c_imag   = c_im;
endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Bench for mandelbrot_iter_ctrl with a behavioural z^2+c / |z|^2>4 model as the iteration logic.
module tb_mandelbrot_iter_ctrl;
    localparam int Q_LEN    = 46;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 255;
    localparam int TAG_W    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mandelbrot_iter_ctrl_if #(.Q_LEN(Q_LEN), .ITER_W(ITER_W), .TAG_W(TAG_W)) bus ();

    mandelbrot_iter_ctrl #(
        .Q_LEN(Q_LEN), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER), .TAG_W(TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference iteration logic in Q5.40: full-precision products, strict |z|^2 > 4.
    logic signed [91:0] zr_x, zi_x, rr, ii, ri, mag;
    always_comb begin
        zr_x = {{46{bus.lg_z_real[45]}}, bus.lg_z_real};
        zi_x = {{46{bus.lg_z_imag[45]}}, bus.lg_z_imag};
        rr   = zr_x * zr_x;
        ii   = zi_x * zi_x;
        ri   = zr_x * zi_x;
        mag  = rr + ii;
        bus.lg_finished    = (mag > (92'sd4 <<< 80));
        bus.lg_next_z_real = 46'((rr - ii) >>> 40) + bus.lg_c_real;
        bus.lg_next_z_imag = 46'((ri <<< 1) >>> 40) + bus.lg_c_imag;
    end

    localparam logic [45:0] ONE   = 46'd1 << 40;
    localparam logic [45:0] THREE = 46'd3 << 40;

    typedef struct {
        logic [45:0] cr;
        logic [45:0] ci;
        logic [19:0] tag;
        logic [7:0]  iter;
        logic        esc;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0]  iter;
        logic        esc;
        logic [19:0] tag;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; offers a pixel for one edge and records its expected result.
    task automatic send_pixel(input logic [45:0] cr, input logic [45:0] ci, input logic [19:0] tag,
                              input logic [7:0] iter, input logic esc);
        res_t r;
        check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_c_real = cr;
        bus.in_c_imag = ci;
        bus.in_tag    = tag;
        r.iter = iter;
        r.esc  = esc;
        r.tag  = tag;
        sb.push_back(r);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 1000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_result(input string nm);
        res_t r;
        if (sb.size() == 0) begin
            check({nm, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            r = sb.pop_front();
            check({nm, "_iter"}, {56'd0, bus.out_iter}, {56'd0, r.iter});
            check({nm, "_escaped"}, {63'd0, bus.out_escaped}, {63'd0, r.esc});
            check({nm, "_tag"}, {44'd0, bus.out_tag}, {44'd0, r.tag});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
        check({nm, "_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    vec_t vecs[5];
    int   lat;
    logic stable;

    initial begin
        vecs[0] = '{cr: 46'd0,          ci: 46'd0,  tag: 20'h00001, iter: 8'd255, esc: 1'b0, lat: 256};
        vecs[1] = '{cr: THREE,          ci: 46'd0,  tag: 20'h00002, iter: 8'd1,   esc: 1'b1, lat: 2};
        vecs[2] = '{cr: -(ONE + ONE),   ci: 46'd0,  tag: 20'h00003, iter: 8'd255, esc: 1'b0, lat: 256};
        vecs[3] = '{cr: ONE >> 1,       ci: 46'd0,  tag: 20'h00004, iter: 8'd5,   esc: 1'b1, lat: 6};
        vecs[4] = '{cr: 46'd0,          ci: THREE,  tag: 20'hFFFFF, iter: 8'd1,   esc: 1'b1, lat: 2};

        bus.in_valid  = 1'b0;
        bus.in_c_real = '0;
        bus.in_c_imag = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready",  {63'd0, bus.in_ready},    64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid},   64'd0);
        check("rst_busy",      {63'd0, bus.busy},        64'd0);
        check("rst_out_iter",  {56'd0, bus.out_iter},    64'd0);
        check("rst_out_esc",   {63'd0, bus.out_escaped}, 64'd0);
        check("rst_out_tag",   {44'd0, bus.out_tag},     64'd0);
        check("rst_z_real",    {18'd0, bus.lg_z_real},   64'd0);
        check("rst_c_real",    {18'd0, bus.lg_c_real},   64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_pixel(vecs[i].cr, vecs[i].ci, vecs[i].tag, vecs[i].iter, vecs[i].esc);
            check($sformatf("vec%0d_busy", i), {63'd0, bus.busy}, 64'd1);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            take_result($sformatf("vec%0d", i));
        end

        // z register trace for c=3.0: 0 after accept, 3.0 after one step, unchanged on escape.
        send_pixel(THREE, 46'd0, 20'h00A00, 8'd1, 1'b1);
        check("z3_after_accept", {18'd0, bus.lg_z_real}, 64'd0);
        check("c3_latched",      {18'd0, bus.lg_c_real}, {18'd0, THREE});
        @(posedge clk);
        @(negedge clk);
        check("z3_after_step",   {18'd0, bus.lg_z_real}, {18'd0, THREE});
        @(posedge clk);
        @(negedge clk);
        check("z3_held_on_esc",  {18'd0, bus.lg_z_real}, {18'd0, THREE});
        check("z3_valid",        {63'd0, bus.out_valid}, 64'd1);
        take_result("z3");

        // Backpressure for 10 cycles, then a back-to-back second pixel.
        send_pixel(THREE, 46'd0, 20'h00AAA, 8'd1, 1'b1);
        wait_result(lat);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(bus.out_valid && !bus.in_ready && bus.out_iter == 8'd1 &&
                  bus.out_escaped && bus.out_tag == 20'h00AAA)) stable = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_stable", {63'd0, stable}, 64'd1);
        take_result("bp_first");
        send_pixel(46'd0, THREE, 20'h00BBB, 8'd1, 1'b1);
        wait_result(lat);
        check("bp_second_latency", 64'(lat), 64'd2);
        take_result("bp_second");

        // Reset in the middle of a long iteration drops the pixel.
        send_pixel(46'd0, 46'd0, 20'h12345, 8'd255, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.in_ready},  64'd1);
        check("mid_rst_z",     {18'd0, bus.lg_z_real}, 64'd0);
        check("mid_rst_tag",   {44'd0, bus.out_tag},   64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pixel(THREE, 46'd0, 20'h54321, 8'd1, 1'b1);
        wait_result(lat);
        check("post_rst_latency", 64'(lat), 64'd2);
        take_result("post_rst");

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
